// File: rtl/draw_scheduler.sv
// draw_scheduler: frame-level arbiter sharing one framebuffer write port
// between drawing engines, with clipping and a per-grant watchdog.
module draw_scheduler #(
  parameter int N_CLIENTS = 4,
  parameter int TIMEOUT   = 20000,
  parameter int X_MAX     = 159,
  parameter int Y_MAX     = 119
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [N_CLIENTS-1:0]   req,
  input  logic [N_CLIENTS-1:0]   done,
  input  logic [8*N_CLIENTS-1:0] client_x,
  input  logic [7*N_CLIENTS-1:0] client_y,
  input  logic [3*N_CLIENTS-1:0] client_color,
  input  logic [N_CLIENTS-1:0]   client_plot,
  input  logic                   err_clear,
  output logic [N_CLIENTS-1:0]   grant,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_color,
  output logic                   vga_plot,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, GAP} state_t;

  state_t               state, state_n;
  logic [N_CLIENTS-1:0] pending, pending_n;
  logic [N_CLIENTS-1:0] grant_n, first;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 busy_n, done_n;
  logic                 ovr_set, to_set, hit;
  logic [7:0]           sel_x;
  logic [6:0]           sel_y;
  logic [2:0]           sel_c;
  logic                 sel_p;

  // lowest-index pending client wins
  always_comb begin
    first = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--)
      if (pending[i]) first = N_CLIENTS'(1) << i;
  end

  assign hit = (grant & done) != '0;

  always_comb begin
    state_n   = state;
    pending_n = pending;
    grant_n   = grant;
    cnt_n     = cnt;
    busy_n    = frame_busy;
    done_n    = 1'b0;
    to_set    = 1'b0;
    ovr_set   = frame_tick & (frame_busy | frame_done);
    unique case (state)
      IDLE: begin
        if (frame_tick && !frame_done) begin
          pending_n = req;
          busy_n    = 1'b1;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        if (pending == '0) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          grant_n = first;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        cnt_n = cnt + 1'b1;
        if (hit || cnt == CNT_LAST) begin
          to_set    = !hit;
          pending_n = pending & ~grant;
          grant_n   = '0;
          state_n   = GAP;
        end
      end
      GAP: state_n = SCAN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      grant       <= '0;
      cnt         <= '0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      grant       <= grant_n;
      cnt         <= cnt_n;
      frame_busy  <= busy_n;
      frame_done  <= done_n;
      overrun     <= ovr_set | (overrun & ~err_clear);
      timeout_err <= to_set | (timeout_err & ~err_clear);
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_c = '0;
    sel_p = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant[i]) begin
        sel_x = client_x[8*i +: 8];
        sel_y = client_y[7*i +: 7];
        sel_c = client_color[3*i +: 3];
        sel_p = client_plot[i];
      end
    end
  end

  // coordinates hold while nobody is granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_plot  <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      if (grant != '0) begin
        vga_x     <= sel_x;
        vga_y     <= sel_y;
        vga_color <= sel_c;
        vga_plot  <= sel_p & (sel_x <= XM) & (sel_y <= YM);
      end
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: randomized engines plus directed frames, checked
// every cycle against a behavioural schedule model.
module tb_draw_scheduler;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clock = 0;
  logic           reset = 1;
  logic           frame_tick = 0;
  logic           err_clear = 0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   done = '0;
  logic [N-1:0]   client_plot = '0;
  logic [8*N-1:0] client_x = '0;
  logic [7*N-1:0] client_y = '0;
  logic [3*N-1:0] client_color = '0;
  logic [N-1:0]   grant;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_color;
  logic           vga_plot, frame_busy, frame_done;
  logic           overrun, timeout_err;

  draw_scheduler #(.N_CLIENTS(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .req(req), .done(done), .client_x(client_x),
    .client_y(client_y), .client_color(client_color),
    .client_plot(client_plot), .err_clear(err_clear),
    .grant(grant), .vga_x(vga_x), .vga_y(vga_y),
    .vga_color(vga_color), .vga_plot(vga_plot),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // behavioural model: frame = list of pending clients served in index order
  bit       m_busy, m_done, m_ovr, m_to, m_scan;
  bit [N-1:0] m_pend;
  int       m_cur, m_age;
  int       ex_x, ex_y, ex_c;
  bit       ex_plot;
  bit       so, st, nd;

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_ovr = 0; m_to = 0; m_scan = 0;
      m_pend = '0; m_cur = -1; m_age = 0;
      ex_x = 0; ex_y = 0; ex_c = 0; ex_plot = 0;
    end else begin
      so = frame_tick && (m_busy || m_done);
      st = 0;
      nd = 0;
      if (m_cur >= 0) begin
        ex_x = int'(client_x[8*m_cur +: 8]);
        ex_y = int'(client_y[7*m_cur +: 7]);
        ex_c = int'(client_color[3*m_cur +: 3]);
        ex_plot = client_plot[m_cur] && ex_x <= 159 && ex_y <= 119;
      end else ex_plot = 0;
      if (!m_busy) begin
        if (frame_tick && !m_done) begin
          m_pend = req; m_busy = 1; m_scan = 1;
        end
      end else if (m_scan) begin
        m_scan = 0;
        if (m_pend == '0) begin
          m_busy = 0; nd = 1;
        end else begin
          m_cur = lowest(m_pend); m_age = 0;
        end
      end else if (m_cur >= 0) begin
        if (done[m_cur] || m_age == TO - 1) begin
          st = !done[m_cur];
          m_pend[m_cur] = 0;
          m_cur = -1;
        end else m_age++;
      end else m_scan = 1;
      m_done = nd;
      m_ovr = so || (m_ovr && !err_clear);
      m_to = st || (m_to && !err_clear);
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("grant", int'(grant), (m_cur >= 0) ? (1 << m_cur) : 0);
      chk("frame_busy", int'(frame_busy), int'(m_busy));
      chk("frame_done", int'(frame_done), int'(m_done));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("timeout_err", int'(timeout_err), int'(m_to));
      chk("vga_plot", int'(vga_plot), int'(ex_plot));
      chk("vga_x", int'(vga_x), ex_x);
      chk("vga_y", int'(vga_y), ex_y);
      chk("vga_color", int'(vga_color), ex_c);
    end
  end

  // engines: granted client pulses done after dly[i] grant cycles
  int gcnt[N] = '{default: 0};
  int dly[N] = '{default: 0};
  bit rand_mode = 0;

  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        done[i] = (gcnt[i] == dly[i]);
        gcnt[i]++;
      end else begin
        gcnt[i] = 0;
        done[i] = rand_mode && ($urandom_range(7) == 0);
      end
      if (rand_mode) begin
        client_x[8*i +: 8] = 8'($urandom_range(175));
        client_y[7*i +: 7] = 7'($urandom_range(127));
        client_color[3*i +: 3] = 3'($urandom_range(7));
        client_plot[i] = 1'($urandom_range(1));
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && frame_busy; k++) step();
    chk(name, int'(frame_busy), 0);
  endtask

  task automatic clear_errs();
    err_clear = 1;
    step();
    err_clear = 0;
  endtask

  int busy_n, done_n, fd_at, g0, g1, to_fall;
  bit after, g1_seen;
  logic [N-1:0] order[$];
  logic [N-1:0] last;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(frame_busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    chk("rst_plot", int'(vga_plot), 0);
    @(negedge clock);
    #1 reset = 0;
    step();

    // fixed-priority order with a skipped client
    foreach (dly[i]) dly[i] = 10;
    req = 4'b1011;
    frame_tick = 1; step(); frame_tick = 0;
    busy_n = 0; done_n = 0; fd_at = -1; last = '0;
    for (int k = 0; k < 60; k++) begin
      if (frame_busy) busy_n++;
      if (frame_done) begin
        done_n++;
        if (fd_at < 0) fd_at = k;
      end
      if (grant != '0 && grant != last) order.push_back(grant);
      if (grant != '0) last = grant;
      step();
    end
    chk("order_len", order.size(), 3);
    if (order.size() == 3) begin
      chk("order_0", int'(order[0]), 1);
      chk("order_1", int'(order[1]), 2);
      chk("order_2", int'(order[2]), 8);
    end
    chk("frame_busy_len", busy_n, 40);
    chk("frame_done_cycle", fd_at, 40);
    chk("frame_done_count", done_n, 1);

    // pixel forwarding and clipping
    dly[0] = 255;
    req = 4'b0001;
    frame_tick = 1; step(); frame_tick = 0;
    step();
    chk("pix_grant", int'(grant), 1);
    client_x[7:0] = 8'd5;   client_y[6:0] = 7'd7;
    client_color[2:0] = 3'd7; client_plot[0] = 1;
    client_x[23:16] = 8'd99; client_y[20:14] = 7'd99;
    client_color[8:6] = 3'd2; client_plot[2] = 1;
    step();
    chk("pix_x", int'(vga_x), 5);
    chk("pix_y", int'(vga_y), 7);
    chk("pix_color", int'(vga_color), 7);
    chk("pix_plot", int'(vga_plot), 1);
    client_x[7:0] = 8'd160; client_y[6:0] = 7'd10;
    step();
    chk("clip_x160", int'(vga_plot), 0);
    client_x[7:0] = 8'd159; client_y[6:0] = 7'd119;
    step();
    chk("edge_159_119", int'(vga_plot), 1);
    client_x[7:0] = 8'd10; client_y[6:0] = 7'd120;
    step();
    chk("clip_y120", int'(vga_plot), 0);
    client_plot = '0;
    wait_idle("pix_frame_end");
    step();
    clear_errs();

    // watchdog release
    dly[1] = 3;
    req = 4'b0011;
    frame_tick = 1; step(); frame_tick = 0;
    g0 = 0; after = 0; to_fall = 0; g1_seen = 0;
    for (int k = 0; k < 80 && frame_busy; k++) begin
      if (grant == 4'b0001) g0++;
      if (grant == '0 && g0 > 0 && !after) begin
        after = 1;
        to_fall = int'(timeout_err);
      end
      if (grant == 4'b0010) g1_seen = 1;
      step();
    end
    chk("to_grant_cycles", g0, 16);
    chk("to_err_at_release", to_fall, 1);
    chk("to_next_client", int'(g1_seen), 1);
    step();
    clear_errs();
    chk("to_err_cleared", int'(timeout_err), 0);

    // overrun and empty frames
    foreach (dly[i]) dly[i] = 5;
    req = 4'b0111;
    frame_tick = 1; step(); frame_tick = 0;
    repeat (5) step();
    frame_tick = 1; step(); frame_tick = 0;
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_busy", int'(frame_busy), 1);
    wait_idle("ovr_frame_end");
    chk("ovr_frame_done", int'(frame_done), 1);
    step();
    clear_errs();
    chk("ovr_cleared", int'(overrun), 0);
    req = '0;
    frame_tick = 1; step(); frame_tick = 0;
    chk("empty_busy", int'(frame_busy), 1);
    chk("empty_done_1", int'(frame_done), 0);
    step();
    chk("empty_done_2", int'(frame_done), 1);
    chk("empty_grant", int'(grant), 0);
    frame_tick = 1; step(); frame_tick = 0;
    chk("tick_on_done_ovr", int'(overrun), 1);
    chk("tick_on_done_idle", int'(frame_busy), 0);
    step();
    chk("tick_on_done_nostart", int'(frame_busy), 0);
    clear_errs();

    // asynchronous reset mid-grant
    dly[1] = 255;
    req = 4'b0010;
    frame_tick = 1; step(); frame_tick = 0;
    repeat (11) step();
    chk("pre_reset_grant", int'(grant), 2);
    #2 reset = 1;
    #1;
    chk("arst_grant", int'(grant), 0);
    chk("arst_plot", int'(vga_plot), 0);
    chk("arst_busy", int'(frame_busy), 0);
    @(negedge clock);
    #1 reset = 0;
    dly[1] = 4;
    step();
    frame_tick = 1; step(); frame_tick = 0;
    step();
    chk("regrant", int'(grant), 2);
    g1 = 0;
    for (int k = 0; k < 20; k++) begin
      if (grant == 4'b0010) g1++;
      step();
    end
    chk("regrant_cycles", g1, 5);

    // randomized frames
    rand_mode = 1;
    for (int f = 0; f < 30; f++) begin
      req = 4'($urandom);
      foreach (dly[i])
        dly[i] = ($urandom_range(5) == 0) ? 255 : int'($urandom_range(8));
      frame_tick = 1; step(); frame_tick = 0;
      for (int k = 0; k < 200 && frame_busy; k++) begin
        frame_tick = ($urandom_range(40) == 0);
        err_clear = ($urandom_range(25) == 0);
        req = 4'($urandom);
        step();
      end
      frame_tick = 0;
      err_clear = 0;
      chk("rand_frame_end", int'(frame_busy), 0);
      repeat ($urandom_range(2)) step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
